// File: rtl/mdu_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_sequencer_if
//  Description : Bus bundle for the RV32M multiply/divide sequencer. It groups
//                the execute-stage issue handshake, the M-ALU operand/result
//                path and the writeback retire handshake. Signal prefixes are
//                taken from the sequencer's point of view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mdu_sequencer_if;
  // Issue side (execute stage -> sequencer)
  logic        i_valid;
  logic        o_ready;
  logic [2:0]  i_op;
  logic [31:0] i_rs1;
  logic [31:0] i_rs2;
  logic [4:0]  i_rd;
  logic        i_flush;
  // M-ALU side
  logic [2:0]  o_alu_op;
  logic [31:0] o_alu_x;
  logic [31:0] o_alu_y;
  logic [31:0] i_alu_res;
  // Writeback side (sequencer -> writeback)
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_res;
  logic [4:0]  o_rd;
  logic        o_busy;

  // Sequencer view
  modport slave (
    input  i_valid, i_op, i_rs1, i_rs2, i_rd, i_flush, i_alu_res, i_ready,
    output o_ready, o_alu_op, o_alu_x, o_alu_y, o_valid, o_res, o_rd, o_busy
  );

  // Surrounding pipeline / M-ALU view
  modport master (
    output i_valid, i_op, i_rs1, i_rs2, i_rd, i_flush, i_alu_res, i_ready,
    input  o_ready, o_alu_op, o_alu_x, o_alu_y, o_valid, o_res, o_rd, o_busy
  );
endinterface
`default_nettype wire

// File: rtl/mdu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_sequencer
//  Description : Multi-cycle issue/retire controller for the RV32M M-ALU.
//                Accepts one M-op, holds registered operands on the
//                combinational M-ALU for MUL_CYCLES/DIV_CYCLES cycles, then
//                captures the result and offers it to writeback.
//  Options     : MDU_FAST_PATH_EN - divide-class ops with a zero divisor
//                spend a single EXEC cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_sequencer #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  mdu_sequencer_if.slave bus
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_EXEC = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  // Counter preload is the cycle count minus one: cnt==0 marks the last EXEC cycle
  localparam logic [3:0] c_MUL_CNT = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] c_DIV_CNT = 4'(DIV_CYCLES - 1);

  // Cycle counts must fit the 4-bit counter and be at least one cycle
  generate
    if (MUL_CYCLES < 1 || MUL_CYCLES > 15) begin : g_bad_mul_cycles
      $error("mdu_sequencer: MUL_CYCLES must be in 1..15");
    end
    if (DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_div_cycles
      $error("mdu_sequencer: DIV_CYCLES must be in 1..15");
    end
  endgenerate

  logic [1:0] r_state;
  logic [3:0] r_cnt;
  logic [4:0] r_rd;
  logic [3:0] w_cnt_load;
  logic       w_accept;

  // A new op is taken only in IDLE and never while a flush is being signalled
  always_comb begin
    w_accept = bus.i_valid && (r_state == c_IDLE) && !bus.i_flush;
  end

  // Select the EXEC length from the op class (op[2] set = divide/remainder)
  always_comb begin
    w_cnt_load = bus.i_op[2] ? c_DIV_CNT : c_MUL_CNT;
`ifdef MDU_FAST_PATH_EN
    // A zero divisor needs no iteration: the M-ALU result is already final
    if (bus.i_op[2] && (bus.i_rs2 == 32'd0)) begin
      w_cnt_load = 4'd0;
    end
`endif
  end

  // Handshake and status outputs decode directly from the state
  always_comb begin
    bus.o_ready = (r_state == c_IDLE);
    bus.o_valid = (r_state == c_DONE);
    bus.o_busy  = (r_state != c_IDLE);
  end

  // Main FSM: issue, count down the multicycle window, hold result until retired
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= c_IDLE;
      r_cnt        <= 4'd0;
      r_rd         <= 5'd0;
      bus.o_alu_op <= 3'd0;
      bus.o_alu_x  <= 32'd0;
      bus.o_alu_y  <= 32'd0;
      bus.o_res    <= 32'd0;
      bus.o_rd     <= 5'd0;
    end else if (bus.i_flush) begin
      // Flush overrides both an incoming op and a pending retire handshake
      r_state <= c_IDLE;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            bus.o_alu_op <= bus.i_op;
            bus.o_alu_x  <= bus.i_rs1;
            bus.o_alu_y  <= bus.i_rs2;
            r_rd         <= bus.i_rd;
            r_cnt        <= w_cnt_load;
            r_state      <= c_EXEC;
          end
        end
        c_EXEC: begin
          if (r_cnt == 4'd0) begin
            bus.o_res <= bus.i_alu_res;
            bus.o_rd  <= r_rd;
            r_state   <= c_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        c_DONE: begin
          if (bus.i_ready) begin
            r_state <= c_IDLE;
          end
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu_sequencer
//  Description : Self-checking bench for mdu_sequencer with a reference RV32M
//                M-ALU model and a result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mdu_sequencer;

  localparam int MUL_C = 2;
  localparam int DIV_C = 8;
`ifdef MDU_FAST_PATH_EN
  localparam int FAST_C = 1;
`else
  localparam int FAST_C = DIV_C;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   retires      = 0;
  int   cyc          = 0;
  logic [36:0] sb_q[$];
  logic [36:0] m_exp;

  mdu_sequencer_if bus();

  mdu_sequencer #(.MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference RV32M semantics
  function automatic logic [31:0] m_alu(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    logic [31:0] r;
    logic        ovf;
    r   = 32'd0;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (op)
      3'b000: begin p = {32'd0, x} * {32'd0, y}; r = p[31:0]; end
      3'b001: begin p = {{32{x[31]}}, x} * {{32{y[31]}}, y}; r = p[63:32]; end
      3'b010: begin p = {{32{x[31]}}, x} * {32'd0, y}; r = p[63:32]; end
      3'b011: begin p = {32'd0, x} * {32'd0, y}; r = p[63:32]; end
      3'b100: begin
        if (y == 32'd0) r = 32'hFFFF_FFFF;
        else if (ovf)   r = x;
        else            r = $signed(x) / $signed(y);
      end
      3'b101: r = (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
      3'b110: begin
        if (y == 32'd0) r = x;
        else if (ovf)   r = 32'd0;
        else            r = $signed(x) % $signed(y);
      end
      default: r = (y == 32'd0) ? x : x % y;
    endcase
    return r;
  endfunction

  // Combinational M-ALU driven from the sequencer's registered operands
  assign bus.i_alu_res = m_alu(bus.o_alu_op, bus.o_alu_x, bus.o_alu_y);

  // Scoreboard: every accepted retire handshake pops and compares one entry
  always @(negedge clk) begin
    if (!rst && bus.o_valid && bus.i_ready && !bus.i_flush) begin
      tests_run++;
      retires++;
      if (sb_q.size() == 0) begin
        tests_failed++;
        $display("FAIL retire_unexpected: got rd=%0d res=%h, required no retire", bus.o_rd, bus.o_res);
      end else begin
        m_exp = sb_q.pop_front();
        if ({bus.o_rd, bus.o_res} !== m_exp) begin
          tests_failed++;
          $display("FAIL retire_data: got rd=%0d res=%h, required rd=%0d res=%h",
                   bus.o_rd, bus.o_res, m_exp[36:32], m_exp[31:0]);
        end
      end
    end
  end

  // Drive one op; returns #1 after the accepting edge with the expectation queued
  task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, input logic [4:0] rd);
    bus.i_valid = 1'b1;
    bus.i_op    = op;
    bus.i_rs1   = x;
    bus.i_rs2   = y;
    bus.i_rd    = rd;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    sb_q.push_back({rd, m_alu(op, x, y)});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (bus.o_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b, required 1", bus.o_ready); end
    tests_run++;
    if (bus.o_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b, required 0", bus.o_valid); end
    tests_run++;
    if (bus.o_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, required 0", bus.o_busy); end
    tests_run++;
    if (bus.o_res !== 32'd0) begin tests_failed++; $display("FAIL reset_res: got %h, required 0", bus.o_res); end
    tests_run++;
    if ({bus.o_rd, bus.o_alu_op, bus.o_alu_x, bus.o_alu_y} !== 72'd0) begin
      tests_failed++;
      $display("FAIL reset_regs: got rd=%0d op=%0d x=%h y=%h, required all 0", bus.o_rd, bus.o_alu_op, bus.o_alu_x, bus.o_alu_y);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    int first;
    int busy;
    first = -1;
    busy  = 0;
    bus.i_ready = 1'b1;
    issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
    for (int i = 0; i < 8; i++) begin
      if (bus.o_busy) busy++;
      if (bus.o_busy && !bus.o_valid) begin
        tests_run++;
        if ({bus.o_alu_op, bus.o_alu_x, bus.o_alu_y} !== {3'b000, 32'd7, 32'hFFFF_FFFD}) begin
          tests_failed++;
          $display("FAIL mul_operand_hold: got op=%0d x=%h y=%h, required op=0 x=7 y=fffffffd", bus.o_alu_op, bus.o_alu_x, bus.o_alu_y);
        end
      end
      if (bus.o_valid && first < 0) begin
        first = i;
        tests_run++;
        if (bus.o_res !== 32'hFFFF_FFEB || bus.o_rd !== 5'd5) begin
          tests_failed++;
          $display("FAIL mul_result: got res=%h rd=%0d, required res=ffffffeb rd=5", bus.o_res, bus.o_rd);
        end
      end
      @(posedge clk); #1;
    end
    tests_run++;
    if (first !== MUL_C) begin tests_failed++; $display("FAIL mul_latency: got %0d, required %0d", first, MUL_C); end
    tests_run++;
    if (busy !== MUL_C + 1) begin tests_failed++; $display("FAIL mul_busy_cycles: got %0d, required %0d", busy, MUL_C + 1); end
  endtask

  task automatic test_divu_stall();
    int n;
    bus.i_ready = 1'b0;
    issue(3'b101, 32'd100, 32'd7, 5'd9);
    n = 0;
    while (!bus.o_valid && n < 40) begin @(posedge clk); #1; n++; end
    tests_run++;
    if (n !== DIV_C) begin tests_failed++; $display("FAIL divu_latency: got %0d, required %0d", n, DIV_C); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (bus.o_valid !== 1'b1 || bus.o_res !== 32'd14 || bus.o_rd !== 5'd9 || bus.o_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL divu_stall_hold: got valid=%b res=%h rd=%0d ready=%b, required valid=1 res=e rd=9 ready=0",
                 bus.o_valid, bus.o_res, bus.o_rd, bus.o_ready);
      end
    end
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL divu_release: got valid=%b ready=%b, required valid=0 ready=1", bus.o_valid, bus.o_ready);
    end
  endtask

  task automatic test_flush_exec();
    int n;
    bus.i_ready = 1'b1;
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3);
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL flush_pre_exec: got valid=%b busy=%b, required valid=0 busy=1", bus.o_valid, bus.o_busy);
      end
      @(posedge clk); #1;
    end
    bus.i_flush = 1'b1;
    @(posedge clk); #1;
    bus.i_flush = 1'b0;
    void'(sb_q.pop_back());
    tests_run++;
    if (bus.o_busy !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_exec_idle: got busy=%b ready=%b valid=%b, required busy=0 ready=1 valid=0",
               bus.o_busy, bus.o_ready, bus.o_valid);
    end
    issue(3'b000, 32'd3, 32'd4, 5'd1);
    tests_run++;
    if (bus.o_busy !== 1'b1) begin tests_failed++; $display("FAIL flush_next_accept: got busy=%b, required 1", bus.o_busy); end
    n = 0;
    while (!bus.o_valid && n < 40) begin @(posedge clk); #1; n++; end
    tests_run++;
    if (n !== MUL_C) begin tests_failed++; $display("FAIL flush_next_latency: got %0d, required %0d", n, MUL_C); end
    @(posedge clk); #1;
  endtask

  task automatic test_fast_path();
    int n;
    bus.i_ready = 1'b1;
    issue(3'b110, 32'hFFFF_FFF9, 32'd0, 5'd12);
    n = 0;
    while (!bus.o_valid && n < 40) begin @(posedge clk); #1; n++; end
    tests_run++;
    if (n !== FAST_C) begin tests_failed++; $display("FAIL rem_zero_latency: got %0d, required %0d", n, FAST_C); end
    tests_run++;
    if (bus.o_res !== 32'hFFFF_FFF9) begin tests_failed++; $display("FAIL rem_zero_result: got %h, required fffffff9", bus.o_res); end
    @(posedge clk); #1;
    issue(3'b101, 32'h0000_1234, 32'd0, 5'd13);
    n = 0;
    while (!bus.o_valid && n < 40) begin @(posedge clk); #1; n++; end
    tests_run++;
    if (n !== FAST_C) begin tests_failed++; $display("FAIL divu_zero_latency: got %0d, required %0d", n, FAST_C); end
    @(posedge clk); #1;
    issue(3'b000, 32'd5, 32'd0, 5'd14);
    n = 0;
    while (!bus.o_valid && n < 40) begin @(posedge clk); #1; n++; end
    tests_run++;
    if (n !== MUL_C) begin tests_failed++; $display("FAIL mul_zero_latency: got %0d, required %0d", n, MUL_C); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush_collision();
    int n;
    int r;
    bus.i_valid = 1'b1;
    bus.i_flush = 1'b1;
    bus.i_op    = 3'b000;
    bus.i_rs1   = 32'd11;
    bus.i_rs2   = 32'd12;
    bus.i_rd    = 5'd2;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
    tests_run++;
    if (bus.o_busy !== 1'b0 || bus.o_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_idle_collision: got busy=%b ready=%b, required busy=0 ready=1", bus.o_busy, bus.o_ready);
    end
    bus.i_ready = 1'b0;
    issue(3'b001, 32'hDEAD_BEEF, 32'h1234_5678, 5'd20);
    n = 0;
    while (!bus.o_valid && n < 40) begin @(posedge clk); #1; n++; end
    tests_run++;
    if (n !== MUL_C) begin tests_failed++; $display("FAIL mulh_latency: got %0d, required %0d", n, MUL_C); end
    r = retires;
    bus.i_ready = 1'b1;
    bus.i_flush = 1'b1;
    @(posedge clk); #1;
    bus.i_flush = 1'b0;
    void'(sb_q.pop_back());
    tests_run++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 || retires !== r) begin
      tests_failed++;
      $display("FAIL flush_done_collision: got valid=%b ready=%b retires=%0d, required valid=0 ready=1 retires=%0d",
               bus.o_valid, bus.o_ready, retires, r);
    end
  endtask

  task automatic test_reset_mid_op();
    bus.i_ready = 1'b1;
    issue(3'b111, 32'd1000, 32'd33, 5'd7);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(sb_q.pop_back());
    tests_run++;
    if (bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0 || bus.o_res !== 32'd0 || bus.o_rd !== 5'd0 || bus.o_alu_x !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_op: got busy=%b valid=%b res=%h rd=%0d x=%h, required all 0",
               bus.o_busy, bus.o_valid, bus.o_res, bus.o_rd, bus.o_alu_x);
    end
    for (int i = 0; i < DIV_C + 2; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (bus.o_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_mid_op_leak: got valid=%b, required 0", bus.o_valid); end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int acc_cyc;
    int last_acc;
    int last_c;
    logic acc;
    logic [2:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  rd;
    last_acc = 0;
    last_c   = 0;
    bus.i_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      op = 3'($urandom_range(0, 7));
      x  = $urandom;
      y  = $urandom | 32'd1;
      rd = 5'($urandom_range(1, 31));
      bus.i_valid = 1'b1;
      bus.i_op    = op;
      bus.i_rs1   = x;
      bus.i_rs2   = y;
      bus.i_rd    = rd;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 40) begin
        @(negedge clk);
        acc = bus.o_ready;
        @(posedge clk); #1;
        n++;
      end
      acc_cyc = cyc;
      sb_q.push_back({rd, m_alu(op, x, y)});
      if (j > 0) begin
        tests_run++;
        if (!acc || (acc_cyc - last_acc) !== last_c + 2) begin
          tests_failed++;
          $display("FAIL b2b_spacing: got %0d cycles (accepted=%b), required %0d", acc_cyc - last_acc, acc, last_c + 2);
        end
      end
      last_acc = acc_cyc;
      last_c   = op[2] ? DIV_C : MUL_C;
    end
    bus.i_valid = 1'b0;
    n = 0;
    while ((sb_q.size() != 0 || bus.o_busy) && n < 60) begin @(posedge clk); #1; n++; end
    tests_run++;
    if (sb_q.size() != 0) begin tests_failed++; $display("FAIL b2b_drain: got %0d pending, required 0", sb_q.size()); end
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_op    = 3'd0;
    bus.i_rs1   = 32'd0;
    bus.i_rs2   = 32'd0;
    bus.i_rd    = 5'd0;
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b0;
    test_reset();
    test_mul();
    test_divu_stall();
    test_flush_exec();
    test_fast_path();
    test_flush_collision();
    test_reset_mid_op();
    test_back_to_back();
    tests_run++;
    if (retires !== 14) begin tests_failed++; $display("FAIL retire_count: got %0d, required 14", retires); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time bound so a stuck handshake can never hang the run
  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
